dmem_unit: RTL and testbench

- Data-memory stage directly downstream of the single-cycle `cpu` core.
- Consumes the core's `alu` (effective address), `data` (store data), `d_ram_rena` and `d_ram_wena`.
- Returns load data on the core's `mem` input within the same cycle.
- Handles MIPS sub-word loads/stores (lw/lh/lhu/lb/lbu/sw/sh/sb), logs the first access fault in sticky registers, and keeps load/store event counters for debug.

---
 rtl/mips_mem_pkg.sv | 31 +++
 rtl/dmem_unit_if.sv | 14 +
 rtl/dmem_lane_align.sv | 58 +++++
 rtl/dmem_unit.sv | 127 ++++++++++++
 tb/tb_dmem_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory stage: access types, fault causes
// and the default base address of the data segment.
package mips_mem_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    typedef enum logic [2:0] {
        OP_WORD   = 3'd0,
        OP_HALF_S = 3'd1,
        OP_HALF_U = 3'd2,
        OP_BYTE_S = 3'd3,
        OP_BYTE_U = 3'd4
    } mem_op_e;

    typedef enum logic [2:0] {
        FLT_NONE     = 3'd0,
        FLT_MISALIGN = 3'd1,
        FLT_RANGE    = 3'd2,
        FLT_CONFLICT = 3'd3,
        FLT_BADOP    = 3'd4
    } fault_code_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_BYTE_U;
    endfunction

    function automatic logic op_is_half(input logic [2:0] op);
        return (op == OP_HALF_S) || (op == OP_HALF_U);
    endfunction

endpackage

// File: rtl/dmem_unit_if.sv
// Core-side load/store bus of the data-memory stage.
interface dmem_unit_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rena;
    logic        wena;
    logic [2:0]  mem_op;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output rena, output wena,
                    output mem_op, input rdata);
    modport slave  (input addr, input wdata, input rena, input wena,
                    input mem_op, output rdata);
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian sub-word lane steering: byte enables and replicated store
// word on the write side, lane select plus sign/zero extension on the read side.
module dmem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [2:0]  mem_op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raw_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] ldata_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Store side: which lanes are written and the data replicated onto them.
    always_comb begin
        be_o    = '0;
        wword_o = '0;
        case (mem_op_i)
            OP_WORD: begin
                be_o    = 4'b1111;
                wword_o = wdata_i;
            end
            OP_HALF_S, OP_HALF_U: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
            end
            OP_BYTE_S, OP_BYTE_U: begin
                be_o    = 4'b0001 << lane_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed half/byte and extend it to 32 bits.
    always_comb begin
        half_sel = lane_i[1] ? raw_i[31:16] : raw_i[15:0];
        case (lane_i)
            2'd0:    byte_sel = raw_i[7:0];
            2'd1:    byte_sel = raw_i[15:8];
            2'd2:    byte_sel = raw_i[23:16];
            default: byte_sel = raw_i[31:24];
        endcase
        case (mem_op_i)
            OP_WORD:   ldata_o = raw_i;
            OP_HALF_S: ldata_o = {{16{half_sel[15]}}, half_sel};
            OP_HALF_U: ldata_o = {16'h0000, half_sel};
            OP_BYTE_S: ldata_o = {{24{byte_sel[7]}}, byte_sel};
            OP_BYTE_U: ldata_o = {24'h000000, byte_sel};
            default:   ldata_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage behind the single-cycle core: word RAM with sub-word
// access, combinational load path, sticky first-fault log and event counters.
module dmem_unit
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned AW          = 11
) (
    input  logic        clk,
    input  logic        rst,
    dmem_unit_if.slave  bus,
    input  logic        fault_clr,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [31:0] bad_addr,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt
);

    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   off;
    logic [AW-1:0] widx;
    logic [31:0]   raw;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic [31:0]   ldata;
    fault_code_e   det_code;
    logic          load_ok;
    logic          store_ok;

    logic          fault_q,     fault_d;
    fault_code_e   fault_code_q, fault_code_d;
    logic [31:0]   bad_addr_q,  bad_addr_d;
    logic [31:0]   load_cnt_q,  load_cnt_d;
    logic [31:0]   store_cnt_q, store_cnt_d;

    assign off  = bus.addr - BASE_ADDR;
    assign widx = off[AW+1:2];
    assign raw  = mem_q[widx];

    dmem_lane_align u_align (
        .mem_op_i (bus.mem_op),
        .lane_i   (off[1:0]),
        .wdata_i  (bus.wdata),
        .raw_i    (raw),
        .be_o     (be),
        .wword_o  (wword),
        .ldata_o  (ldata)
    );

    // Prioritised fault classification of the current request.
    always_comb begin
        det_code = FLT_NONE;
        if (bus.rena || bus.wena) begin
            if (bus.rena && bus.wena)
                det_code = FLT_CONFLICT;
            else if (!op_is_legal(bus.mem_op))
                det_code = FLT_BADOP;
            else if (off >= SPAN)
                det_code = FLT_RANGE;
            else if (((bus.mem_op == OP_WORD) && (off[1:0] != 2'b00)) ||
                     (op_is_half(bus.mem_op) && off[0]))
                det_code = FLT_MISALIGN;
        end
    end

    assign load_ok   = bus.rena && !bus.wena && (det_code == FLT_NONE);
    assign store_ok  = bus.wena && !bus.rena && (det_code == FLT_NONE);
    assign bus.rdata = load_ok ? ldata : '0;

    // Next state of the fault log (clear first, then capture) and counters.
    always_comb begin
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        bad_addr_d   = bad_addr_q;
        if (fault_clr) begin
            fault_d      = 1'b0;
            fault_code_d = FLT_NONE;
            bad_addr_d   = '0;
        end
        if ((det_code != FLT_NONE) && !fault_d) begin
            fault_d      = 1'b1;
            fault_code_d = det_code;
            bad_addr_d   = bus.addr;
        end
        load_cnt_d  = load_ok  ? load_cnt_q  + 32'd1 : load_cnt_q;
        store_cnt_d = store_ok ? store_cnt_q + 32'd1 : store_cnt_q;
    end

    // Fault log and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q      <= 1'b0;
            fault_code_q <= FLT_NONE;
            bad_addr_q   <= '0;
            load_cnt_q   <= '0;
            store_cnt_q  <= '0;
        end else begin
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            bad_addr_q   <= bad_addr_d;
            load_cnt_q   <= load_cnt_d;
            store_cnt_q  <= store_cnt_d;
        end
    end

    // Byte-enabled RAM write; contents are never reset, but an asserted
    // reset suppresses any write pending at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst && store_ok) begin
            if (be[0]) mem_q[widx][7:0]   <= wword[7:0];
            if (be[1]) mem_q[widx][15:8]  <= wword[15:8];
            if (be[2]) mem_q[widx][23:16] <= wword[23:16];
            if (be[3]) mem_q[widx][31:24] <= wword[31:24];
        end
    end

    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign bad_addr   = bad_addr_q;
    assign load_cnt   = load_cnt_q;
    assign store_cnt  = store_cnt_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: directed scenarios followed by random
// traffic, all compared against a byte-array reference model.
module tb_dmem_unit;
    import mips_mem_pkg::*;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int unsigned DW   = 2048;
    localparam int unsigned WIN  = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        fault_clr;
    logic        fault;
    logic [2:0]  fault_code;
    logic [31:0] bad_addr, load_cnt, store_cnt;

    dmem_unit_if bus();

    dmem_unit #(.BASE_ADDR(BASE), .DEPTH_WORDS(DW), .AW(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fault_clr  (fault_clr),
        .fault      (fault),
        .fault_code (fault_code),
        .bad_addr   (bad_addr),
        .load_cnt   (load_cnt),
        .store_cnt  (store_cnt)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]  mb [WIN];
    logic        m_fault;
    logic [2:0]  m_code;
    logic [31:0] m_bad, m_lcnt, m_scnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_code(input logic [31:0] a, input logic [2:0] op,
                                            input logic r, input logic w);
        logic [31:0] o;
        o = a - BASE;
        if (!(r || w)) return 3'd0;
        if (r && w) return 3'd3;
        if (op > 3'd4) return 3'd4;
        if (o >= DW * 4) return 3'd2;
        if (op == 3'd0 && (o % 4) != 0) return 3'd1;
        if ((op == 3'd1 || op == 3'd2) && (o % 2) != 0) return 3'd1;
        return 3'd0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] op);
        int unsigned o;
        logic [31:0] v;
        o = int'(a - BASE);
        case (op)
            3'd0: v = {mb[o+3], mb[o+2], mb[o+1], mb[o]};
            3'd1, 3'd2: begin
                v = {16'h0, mb[o+1], mb[o]};
                if (op == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: begin
                v = {24'h0, mb[o]};
                if (op == 3'd3 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_fault = 1'b0; m_code = 3'd0; m_bad = '0; m_lcnt = '0; m_scnt = '0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".fault"}, {31'd0, fault}, {31'd0, m_fault});
        check({tag, ".code"},  {29'd0, fault_code}, {29'd0, m_code});
        check({tag, ".bad"},   bad_addr, m_bad);
        check({tag, ".lcnt"},  load_cnt, m_lcnt);
        check({tag, ".scnt"},  store_cnt, m_scnt);
    endtask

    // One access: drive, check combinational rdata, clock, update model, check regs.
    task automatic access(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] op, input logic r, input logic w, input logic clr);
        logic [2:0]  c;
        logic [31:0] er;
        int unsigned o;
        bus.addr = a; bus.wdata = wd; bus.mem_op = op; bus.rena = r; bus.wena = w;
        fault_clr = clr;
        #2;
        c  = exp_code(a, op, r, w);
        er = (r && !w && c == 3'd0) ? exp_load(a, op) : 32'd0;
        check({tag, ".rdata"}, bus.rdata, er);
        @(posedge clk);
        #1;
        o = int'(a - BASE);
        if (w && !r && c == 3'd0) begin
            mb[o] = wd[7:0];
            if (op != 3'd3 && op != 3'd4) mb[o+1] = wd[15:8];
            if (op == 3'd0) begin mb[o+2] = wd[23:16]; mb[o+3] = wd[31:24]; end
            m_scnt = m_scnt + 1;
        end
        if (r && !w && c == 3'd0) m_lcnt = m_lcnt + 1;
        if (clr) begin m_fault = 1'b0; m_code = 3'd0; m_bad = '0; end
        if (c != 3'd0 && !m_fault) begin m_fault = 1'b1; m_code = c; m_bad = a; end
        bus.rena = 1'b0; bus.wena = 1'b0; fault_clr = 1'b0;
        check_regs(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, wd, o;
        logic [2:0]  op;
        logic        r, w, clr;
        int unsigned k;

        rst = 1'b1; fault_clr = 1'b0;
        bus.addr = '0; bus.wdata = '0; bus.mem_op = '0; bus.rena = 1'b0; bus.wena = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_regs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Scenario 1: word store and every load flavour.
        access("s1.sw",  BASE + 32'h4, 32'h8000_FF7F, 3'd0, 1'b0, 1'b1, 1'b0);
        access("s1.lw",  BASE + 32'h4, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
        access("s1.lb",  BASE + 32'h4, 32'h0, 3'd3, 1'b1, 1'b0, 1'b0);
        access("s1.lbu", BASE + 32'h5, 32'h0, 3'd4, 1'b1, 1'b0, 1'b0);
        access("s1.lh",  BASE + 32'h6, 32'h0, 3'd1, 1'b1, 1'b0, 1'b0);
        access("s1.lhu", BASE + 32'h6, 32'h0, 3'd2, 1'b1, 1'b0, 1'b0);
        check("s1.store_cnt", store_cnt, 32'd1);
        check("s1.load_cnt",  load_cnt,  32'd5);

        // Scenario 2: sub-word stores preserve neighbouring bytes.
        access("s2.sb", BASE + 32'h5, 32'h0000_00AB, 3'd3, 1'b0, 1'b1, 1'b0);
        bus.addr = BASE + 32'h4; bus.mem_op = 3'd0; bus.rena = 1'b1; #2;
        check("s2.after_sb", bus.rdata, 32'h8000_AB7F);
        access("s2.lw1", BASE + 32'h4, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
        access("s2.sh", BASE + 32'h6, 32'h0000_1234, 3'd1, 1'b0, 1'b1, 1'b0);
        bus.addr = BASE + 32'h4; bus.mem_op = 3'd0; bus.rena = 1'b1; #2;
        check("s2.after_sh", bus.rdata, 32'h1234_AB7F);
        access("s2.lw2", BASE + 32'h4, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);

        // Scenario 3: misaligned load logged; later range fault does not overwrite.
        access("s3.lw_mis", BASE + 32'h2, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
        check("s3.code", {29'd0, fault_code}, 32'd1);
        check("s3.bad",  bad_addr, 32'h1001_0002);
        access("s3.sw_rng", 32'h0000_0000, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b1, 1'b0);
        check("s3.code_kept", {29'd0, fault_code}, 32'd1);

        // Scenario 4: clear together with a new range fault keeps the new one.
        access("s4.sh_rng", BASE + 32'h2000, 32'h5555, 3'd1, 1'b0, 1'b1, 1'b1);
        check("s4.code", {29'd0, fault_code}, 32'd2);
        check("s4.bad",  bad_addr, 32'h1001_2000);

        // Scenario 5: conflict and illegal op.
        access("s5.conf", BASE + 32'h4, 32'hDEAD_BEEF, 3'd0, 1'b1, 1'b1, 1'b1);
        check("s5.code3", {29'd0, fault_code}, 32'd3);
        access("s5.rb", BASE + 32'h4, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
        access("s5.badop", BASE + 32'h8, 32'h0, 3'd5, 1'b1, 1'b0, 1'b1);
        check("s5.code4", {29'd0, fault_code}, 32'd4);

        // Scenario 6: asynchronous reset mid-cycle aborts a pending store.
        @(negedge clk);
        bus.addr = BASE + 32'h4; bus.wdata = 32'hCAFE_F00D; bus.mem_op = 3'd0;
        bus.wena = 1'b1;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_regs("s6.async");
        @(posedge clk); #2;
        bus.wena = 1'b0;
        #1 rst = 1'b0;
        access("s6.rb", BASE + 32'h4, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
        check("s6.rb_const", {mb[7], mb[6], mb[5], mb[4]}, 32'h1234_AB7F);

        // Fill the random window with known contents.
        for (int unsigned i = 0; i < WIN / 4; i++)
            access("init", BASE + 32'(i * 4), $urandom, 3'd0, 1'b0, 1'b1, 1'b0);

        // Random traffic.
        for (int unsigned i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            r = (k <= 3) || (k == 7);
            w = (k >= 4 && k <= 7);
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) begin
                o = ($urandom_range(0, 1) == 0) ? 32'h2000 + 32'($urandom_range(0, 4000))
                                                : 32'hFFFF_FFFF - 32'($urandom_range(0, 64));
            end else begin
                o = 32'($urandom_range(0, WIN - 1));
                if ($urandom_range(0, 4) != 0) begin
                    if (op == 3'd0) o = o & ~32'd3;
                    else if (op == 3'd1 || op == 3'd2) o = o & ~32'd1;
                end
            end
            a   = BASE + o;
            wd  = $urandom;
            clr = ($urandom_range(0, 7) == 0);
            access("rand", a, wd, op, r, w, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
